dbus_wait_bridge: RTL and testbench
===================================

# dbus_wait_bridge

Data-bus bridge between the multicycle RV32 datapath and the data memory/MMIO fabric. It consumes the datapath's single-cycle memory strobes (address, write data, byte enables, read/write enables) and converts each access into a valid/ready transaction toward a memory with variable wait states. It returns read data and a combinational stall that holds the control FSM in its current state until the transfer completes. A timeout counter terminates hung transfers with a bus-error pulse.

## Interface
- TIMEOUT_CYCLES, 16, maximum REQ cycles without iMemReady before the transfer is aborted (≥2)
- ERR_READ_DATA, 32'h0000_0000, value returned on oReadData for an aborted read
- iCLK  in  1  system clock, rising edge
- iRST_n  in  1  reset, asynchronous, active-low
- iAddress  in  32  datapath data address
- iWriteData  in  32  store data, already lane-aligned
- iByteEnable  in  4  store byte lanes
- iWriteEnable  in  1  datapath store strobe, held for the whole control state
- iReadEnable  in  1  datapath load/fetch strobe, held for the whole control state
- oReadData  out  32  captured read data toward MDR/IR
- oStall  out  1  hold control FSM; combinational
- oBusError  out  1  one-cycle pulse on timeout
- oMemValid  out  1  request valid toward memory
- oMemWrite  out  1  1 = write, 0 = read
- oMemAddress  out  32  latched address
- oMemWriteData  out  32  latched write data
- oMemByteEnable  out  4  latched lanes; 4'b1111 for reads
- iMemReady  in  1  memory accepts/completes the transfer this cycle
- iMemReadData  in  32  read data, valid when iMemReady=1 and oMemWrite=0

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: request when iReadEnable|iWriteEnable. On request, latch address, data, and lanes; set oMemWrite=iWriteEnable (write wins if both enables are high); clear the timeout counter; go to REQ.
- REQ: oMemValid=1 and all oMem* outputs are stable.
  - iMemReady=1: capture iMemReadData into oReadData (reads only; writes leave oReadData unchanged) and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with iMemReady=0, go to DONE with abort flag set; for reads, load oReadData with ERR_READ_DATA.
  - If iMemReady and timeout fall in the same cycle, ready wins (normal completion, no error).
- DONE: lasts exactly one cycle. oStall=0 so the datapath samples oReadData and advances. Enables still high in this cycle are ignored (no re-issue). oBusError=1 if abort flag. Then go to IDLE.
- oStall = (state==IDLE & (iReadEnable|iWriteEnable)) | (state==REQ). Combinational, so the control FSM never advances in the accept cycle.
- Counter width: $clog2(TIMEOUT_CYCLES). Saturates, never wraps.
- Enable changes during REQ are ignored; the latched request completes.

## Timing
- Reset (iRST_n=0, asynchronous): state=IDLE, oReadData=0, oBusError=0, oMemValid=0, oMemWrite=0, oMemAddress=0, oMemWriteData=0, oMemByteEnable=0, counter=0, abort=0. oStall then follows the enables combinationally.
- Reset mid-REQ: oMemValid drops immediately and the transaction is abandoned. The memory side must tolerate a withdrawn valid.
- Latency with N wait states (ready in the (N+1)-th REQ cycle): oStall high N+2 cycles, then DONE. Minimum access is 3 cycles (accept, REQ, DONE).
- Timeout: REQ lasts exactly TIMEOUT_CYCLES cycles, then DONE with oBusError.
- Back-to-back: a new request is accepted in the first IDLE cycle after DONE.
- All outputs except oStall are registered.

## Test plan
- Zero-wait read: iMemReady=1, iReadEnable=1, iAddress=0x1001_0004, iMemReadData=0x1234_5678 → oStall high 2 cycles, oMemValid high 1 cycle, DONE with oReadData=0x1234_5678, oStall=0.
- Write, 3 wait states: iWriteEnable=1, iByteEnable=4'b0011, iWriteData=0x0000_BEEF, ready on 4th REQ cycle → oMemWrite=1, oMemByteEnable=4'b0011 held 4 cycles, oStall high 5 cycles, oReadData unchanged.
- Timeout: TIMEOUT_CYCLES=16, read, iMemReady=0 → oMemValid high exactly 16 cycles, DONE with oBusError=1 for 1 cycle, oReadData=ERR_READ_DATA. Repeat with ready on cycle 16 → no error.
- Both enables high, addr 0x1001_0000 → write transfer issued (oMemWrite=1).
- Enables held through DONE, dropped the cycle after → exactly one transaction. A second request immediately after DONE → accepted in the next IDLE cycle.
- iRST_n pulsed low in the 2nd REQ cycle → oMemValid=0 and oReadData=0 immediately. After release with enables low → IDLE, oStall=0.

Source files
------------

// File: rtl/dbus_wait_bridge.sv
// Bridge from the multicycle datapath's held memory strobes to a valid/ready
// memory port with variable wait states, combinational stall and timeout abort.
module dbus_wait_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_READ_DATA  = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  input  logic [3:0]  iByteEnable,
  input  logic        iWriteEnable,
  input  logic        iReadEnable,
  output logic [31:0] oReadData,
  output logic        oStall,
  output logic        oBusError,
  output logic        oMemValid,
  output logic        oMemWrite,
  output logic [31:0] oMemAddress,
  output logic [31:0] oMemWriteData,
  output logic [3:0]  oMemByteEnable,
  input  logic        iMemReady,
  input  logic [31:0] iMemReadData
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_nxt;
  logic          req;
  logic          timeout;
  logic [CW-1:0] cnt;

  assign req = iReadEnable | iWriteEnable;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oStall    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          oStall    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        oStall  = 1'b1;
        // ready in the last counted cycle is a normal completion
        timeout = !iMemReady && (cnt == CNT_LAST);
        if (iMemReady || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oReadData      <= '0;
      oBusError      <= 1'b0;
      oMemValid      <= 1'b0;
      oMemWrite      <= 1'b0;
      oMemAddress    <= '0;
      oMemWriteData  <= '0;
      oMemByteEnable <= '0;
      cnt            <= '0;
    end else begin
      oBusError <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            oMemValid      <= 1'b1;
            oMemWrite      <= iWriteEnable;
            oMemAddress    <= iAddress;
            oMemWriteData  <= iWriteData;
            oMemByteEnable <= iWriteEnable ? iByteEnable : 4'b1111;
            cnt            <= '0;
          end
        end
        REQ: begin
          if (iMemReady) begin
            oMemValid <= 1'b0;
            if (!oMemWrite) oReadData <= iMemReadData;
          end else if (timeout) begin
            oMemValid <= 1'b0;
            oBusError <= 1'b1;
            if (!oMemWrite) oReadData <= ERR_READ_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_wait_bridge.sv
// Directed bench for dbus_wait_bridge: wait states, timeout, write priority,
// no re-issue in DONE, back-to-back accept and reset mid-transfer.
module tb_dbus_wait_bridge;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [3:0]  iByteEnable;
  logic        iWriteEnable;
  logic        iReadEnable;
  logic [31:0] oReadData;
  logic        oStall;
  logic        oBusError;
  logic        oMemValid;
  logic        oMemWrite;
  logic [31:0] oMemAddress;
  logic [31:0] oMemWriteData;
  logic [3:0]  oMemByteEnable;
  logic        iMemReady;
  logic [31:0] iMemReadData;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 iCLK = ~iCLK;

  dbus_wait_bridge #(
    .TIMEOUT_CYCLES(16),
    .ERR_READ_DATA (32'h0000_0000)
  ) dut (
    .iCLK          (iCLK),
    .iRST_n        (iRST_n),
    .iAddress      (iAddress),
    .iWriteData    (iWriteData),
    .iByteEnable   (iByteEnable),
    .iWriteEnable  (iWriteEnable),
    .iReadEnable   (iReadEnable),
    .oReadData     (oReadData),
    .oStall        (oStall),
    .oBusError     (oBusError),
    .oMemValid     (oMemValid),
    .oMemWrite     (oMemWrite),
    .oMemAddress   (oMemAddress),
    .oMemWriteData (oMemWriteData),
    .oMemByteEnable(oMemByteEnable),
    .iMemReady     (iMemReady),
    .iMemReadData  (iMemReadData)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  // Called 1 ns after a rising edge with the request already driven; returns
  // in the DONE cycle. ready_at: 1-based REQ cycle raising iMemReady, 0 = never.
  task automatic run_xfer(input int ready_at, output int stalls, output int valids,
                          output bit held);
    int          reqn = 0;
    bit          done = 0;
    logic        w0   = 1'b0;
    logic [3:0]  be0  = '0;
    logic [31:0] a0   = '0;
    stalls = 0;
    valids = 0;
    held   = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (oMemValid) reqn++;
      iMemReady = oMemValid && (reqn == ready_at);
      #1;
      if (!oStall) begin
        done = 1;
      end else begin
        stalls++;
        if (oMemValid) begin
          valids++;
          if (valids == 1) begin
            w0 = oMemWrite; be0 = oMemByteEnable; a0 = oMemAddress;
          end else if (oMemWrite !== w0 || oMemByteEnable !== be0 || oMemAddress !== a0) begin
            held = 0;
          end
        end
        @(posedge iCLK);
        #1;
      end
    end
    iMemReady = 1'b0;
    if (!done) check("xfer_bound", 32'd0, 32'd1);
  endtask

  int stalls, valids;
  bit held;

  initial begin
    iRST_n = 1'b0; iAddress = '0; iWriteData = '0; iByteEnable = '0;
    iWriteEnable = 1'b0; iReadEnable = 1'b0; iMemReady = 1'b0; iMemReadData = '0;
    #2;
    check("rst_valid", oMemValid, 0);
    check("rst_rdata", oReadData, 0);
    check("rst_addr", oMemAddress, 0);
    check("rst_be", oMemByteEnable, 0);
    check("rst_stall", oStall, 0);
    iReadEnable = 1'b1;
    #1;
    check("rst_stall_comb", oStall, 1);
    iReadEnable = 1'b0;
    tick; tick;
    iRST_n = 1'b1;
    tick;

    // zero-wait read
    iAddress = 32'h1001_0004; iMemReadData = 32'h1234_5678; iReadEnable = 1'b1;
    run_xfer(1, stalls, valids, held);
    check("zw_stalls", stalls, 2);
    check("zw_valids", valids, 1);
    check("zw_rdata", oReadData, 32'h1234_5678);
    check("zw_addr", oMemAddress, 32'h1001_0004);
    check("zw_be", oMemByteEnable, 4'hF);
    check("zw_write", oMemWrite, 0);
    check("zw_berr", oBusError, 0);
    iReadEnable = 1'b0;
    tick;
    check("zw_idle_stall", oStall, 0);
    check("zw_idle_valid", oMemValid, 0);

    // write with 3 wait states
    iAddress = 32'h1001_0008; iWriteData = 32'h0000_BEEF; iByteEnable = 4'b0011;
    iMemReadData = 32'hDEAD_DEAD; iWriteEnable = 1'b1;
    run_xfer(4, stalls, valids, held);
    check("wr_stalls", stalls, 5);
    check("wr_valids", valids, 4);
    check("wr_held", held, 1);
    check("wr_write", oMemWrite, 1);
    check("wr_be", oMemByteEnable, 4'b0011);
    check("wr_wdata", oMemWriteData, 32'h0000_BEEF);
    check("wr_rdata_kept", oReadData, 32'h1234_5678);
    iWriteEnable = 1'b0;
    tick;

    // timeout read
    iAddress = 32'h1001_000C; iMemReadData = 32'h5555_5555; iReadEnable = 1'b1;
    run_xfer(0, stalls, valids, held);
    check("to_stalls", stalls, 17);
    check("to_valids", valids, 16);
    check("to_berr", oBusError, 1);
    check("to_rdata", oReadData, 32'h0000_0000);
    iReadEnable = 1'b0;
    tick;
    check("to_berr_pulse", oBusError, 0);

    // ready in the final counted cycle wins over timeout
    iMemReadData = 32'hCAFE_F00D; iReadEnable = 1'b1;
    run_xfer(16, stalls, valids, held);
    check("rl_valids", valids, 16);
    check("rl_berr", oBusError, 0);
    check("rl_rdata", oReadData, 32'hCAFE_F00D);
    iReadEnable = 1'b0;
    tick;

    // both enables: write wins; enables held through DONE
    iAddress = 32'h1001_0000; iWriteData = 32'hA5A5_A5A5; iByteEnable = 4'b1100;
    iReadEnable = 1'b1; iWriteEnable = 1'b1;
    run_xfer(2, stalls, valids, held);
    check("both_stalls", stalls, 3);
    check("both_write", oMemWrite, 1);
    check("both_be", oMemByteEnable, 4'b1100);
    check("both_rdata_kept", oReadData, 32'hCAFE_F00D);
    tick;
    iReadEnable = 1'b0; iWriteEnable = 1'b0;
    #1;
    check("noreissue_valid", oMemValid, 0);
    check("noreissue_stall", oStall, 0);
    tick;
    check("noreissue_valid2", oMemValid, 0);

    // back-to-back: second request kept high through DONE
    iAddress = 32'h1001_0010; iMemReadData = 32'h0BAD_BEEF; iReadEnable = 1'b1;
    run_xfer(1, stalls, valids, held);
    check("b2b1_rdata", oReadData, 32'h0BAD_BEEF);
    iAddress = 32'h1001_0014; iMemReadData = 32'h600D_F00D;
    tick;
    #1;
    check("b2b_accept_stall", oStall, 1);
    check("b2b_accept_valid", oMemValid, 0);
    run_xfer(1, stalls, valids, held);
    check("b2b2_stalls", stalls, 2);
    check("b2b2_rdata", oReadData, 32'h600D_F00D);
    check("b2b2_addr", oMemAddress, 32'h1001_0014);
    iReadEnable = 1'b0;
    tick;

    // reset in the 2nd REQ cycle
    iAddress = 32'h1001_0018; iReadEnable = 1'b1;
    tick; tick;
    check("mr_valid_before", oMemValid, 1);
    iRST_n = 1'b0;
    #1;
    check("mr_valid", oMemValid, 0);
    check("mr_rdata", oReadData, 0);
    check("mr_addr", oMemAddress, 0);
    iReadEnable = 1'b0;
    tick;
    iRST_n = 1'b1;
    tick;
    check("mr_idle_stall", oStall, 0);
    check("mr_idle_valid", oMemValid, 0);
    check("mr_idle_berr", oBusError, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
